// File: rtl/trace_accumulator.sv
// Per-point sample accumulator over several sync shots.
// After the last shot the summed trace streams out over valid/ready.
module trace_accumulator #(
    parameter int ADC_W = 14,
    parameter int ACC_W = 31,
    parameter int DEPTH = 2048,
    parameter int PTR_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdreq,
    input  logic [ADC_W-1:0] fifo_q,
    input  logic [PTR_W-1:0] points,
    input  logic [16:0]      measures,
    output logic [ACC_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic [16:0]      shot_cnt,
    output logic             overflow
);

    typedef enum logic {ACCUM, DUMP} state_t;

    state_t             state_q;
    logic [PTR_W:0]     k_q;
    logic [16:0]        shot_q;
    logic               ovf_q;
    logic               busy_q;
    logic               ov_q;
    logic               ol_q;
    logic [ACC_W-1:0]   od_q;
    logic               we_q;
    logic [PTR_W-1:0]   wa_q;
    logic [ADC_W-1:0]   smp_q;
    logic               first_q;
    logic               av_q;
    logic               alast_q;
    logic [PTR_W:0]     rp_q;
    logic [ACC_W-1:0]   rd_q;
    logic [ACC_W-1:0]   mem [DEPTH];

    logic [16:0]        tgt;
    logic               in_acc;
    logic               done;
    logic               beat_ok;
    logic               acc_end;
    logic               hs;
    logic               load_b;
    logic               issue;
    logic               rd_en;
    logic [PTR_W-1:0]   rd_addr;
    logic [ACC_W-1:0]   wr_data;

    assign tgt     = (measures == 17'd0) ? 17'd1 : measures;
    assign in_acc  = (state_q == ACCUM);
    assign done    = (shot_q >= tgt);
    assign beat_ok = in_acc && rdreq && !done && (k_q <= {1'b0, points});
    assign acc_end = in_acc && !rdreq && (k_q != '0);
    assign hs      = ov_q && out_ready;
    // Stage A (RAM output) refills whenever the output register frees up.
    assign load_b  = av_q && (!ov_q || out_ready);
    assign issue   = !in_acc && (rp_q <= {1'b0, points}) && (!av_q || load_b);
    assign rd_en   = beat_ok || issue;
    assign rd_addr = in_acc ? k_q[PTR_W-1:0] : rp_q[PTR_W-1:0];
    assign wr_data = first_q ? ACC_W'(smp_q) : rd_q + ACC_W'(smp_q);

    always_ff @(posedge clk) begin
        if (rd_en) rd_q <= mem[rd_addr];
        if (we_q) mem[wa_q] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            k_q     <= '0;
            shot_q  <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            ov_q    <= 1'b0;
            ol_q    <= 1'b0;
            od_q    <= '0;
            we_q    <= 1'b0;
            wa_q    <= '0;
            smp_q   <= '0;
            first_q <= 1'b0;
            av_q    <= 1'b0;
            alast_q <= 1'b0;
            rp_q    <= '0;
        end else begin
            we_q <= beat_ok;
            if (beat_ok) begin
                wa_q    <= k_q[PTR_W-1:0];
                smp_q   <= fifo_q;
                first_q <= (shot_q == 17'd0);
            end
            if (rdreq && !beat_ok) ovf_q <= 1'b1;
            unique case (state_q)
                ACCUM: begin
                    if (rdreq) k_q <= (&k_q) ? k_q : k_q + (PTR_W+1)'(1);
                    else       k_q <= '0;
                    if (acc_end) shot_q <= shot_q + 17'd1;
                    if (done) begin
                        state_q <= DUMP;
                        busy_q  <= 1'b1;
                        rp_q    <= '0;
                        av_q    <= 1'b0;
                        k_q     <= '0;
                    end
                end
                DUMP: begin
                    k_q <= '0;
                    if (issue) begin
                        rp_q    <= rp_q + (PTR_W+1)'(1);
                        av_q    <= 1'b1;
                        alast_q <= (rp_q[PTR_W-1:0] == points);
                    end else if (load_b) begin
                        av_q <= 1'b0;
                    end
                    if (load_b) begin
                        od_q <= rd_q;
                        ov_q <= 1'b1;
                        ol_q <= alast_q;
                    end else if (hs) begin
                        ov_q <= 1'b0;
                    end
                    if (hs && ol_q) begin
                        state_q <= ACCUM;
                        busy_q  <= 1'b0;
                        shot_q  <= '0;
                        ov_q    <= 1'b0;
                        ol_q    <= 1'b0;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign out_data  = od_q;
    assign out_valid = ov_q;
    assign out_last  = ol_q;
    assign busy      = busy_q;
    assign shot_cnt  = shot_q;
    assign overflow  = ovf_q;

endmodule
